scaler_h_ctrl: RTL and testbench
================================

Name: scaler_h_ctrl

Overview:
- Frame-synchronous controller for the horizontal scaler.
- Accepts host scale-step writes, range-checks them, and applies a pending step to the scaler only at a frame start, so a step never changes mid-frame.
- Measures input width/height and scaler output width per frame, flags inconsistent input line widths, and pulses an interrupt at each frame boundary.
- Sits beside the scaler; consumes the same timing strobes fed to the scaler input and observes the scaler output.

Parameters:
PIXEL_STEP, 4096, fixed-point unit of scale step (1.0x)
STEP_MIN, 1024, smallest accepted step (4x upscale)
STEP_MAX, 16384, largest accepted step (4x downscale)
DEFAULT_STEP, 4096, step driven after reset
CNT_WIDTH, 16, width of all pixel/line/frame counters

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
cfg_step_i  in  16  requested scale step
cfg_wr_i  in  1  one-cycle write strobe for cfg_step_i
cfg_pend_o  out  1  accepted step waiting for next frame start
cfg_err_o  out  1  sticky: last write rejected (out of range)
de_i  in  1  input pixel valid
hs_i  in  1  input line-start pulse (1 cycle)
vs_i  in  1  input frame-start pulse (1 cycle, coincides with first hs_i)
scl_de_i  in  1  scaler output pixel valid
scl_hs_i  in  1  scaler output line start; scl_hs_i&scl_de_i marks first output pixel of line
scale_step_o  out  16  step driven to scaler
frame_w_o  out  CNT_WIDTH  input pixels/line, previous frame
frame_h_o  out  CNT_WIDTH  input lines, previous frame
out_w_o  out  CNT_WIDTH  scaler output pixels/line, previous frame
frame_cnt_o  out  CNT_WIDTH  completed frames, wraps
line_err_o  out  1  input line width differed within previous frame
irq_frame_o  out  1  one-cycle pulse when stats published

Behaviour:
- Reset (async, any time, including mid-frame):
  - scale_step_o=DEFAULT_STEP; all other outputs and internal counters 0; pending cleared; state S_WAIT_VS.
- States:
  - S_WAIT_VS: stats not counted.
    - vs_i -> commit pending (if any), clear counters, enter S_ACTIVE.
    - No irq and no stats publish on this first frame start.
  - S_ACTIVE: counting.
    - vs_i -> publish stats, frame_cnt_o+1 (wrap), irq_frame_o=1 for one cycle, commit pending, clear counters, stay S_ACTIVE.
- Config write (cfg_wr_i=1):
  - STEP_MIN <= cfg_step_i <= STEP_MAX: pending register <= cfg_step_i, cfg_pend_o=1 and cfg_err_o=0 next cycle. A later write overwrites the pending value.
  - Otherwise: cfg_err_o=1 next cycle; pending value and cfg_pend_o unchanged.
  - cfg_wr_i in the same cycle as vs_i: the commit uses the value pending before that cycle; the new write stays pending for the following frame.
- Commit: scale_step_o <= pending and cfg_pend_o <= 0, registered one cycle after vs_i. Without a pending value, scale_step_o holds.
- Input counting:
  - hs_i: if pixel counter != 0, the count is a completed line width.
    - First completed line of frame stores the reference width.
    - Any later completed line whose width differs from the reference sets an internal error flag.
  - Pixel counter reloads to de_i (0 or 1) on hs_i; otherwise increments on de_i.
  - Line counter: vs_i&hs_i loads 1; hs_i alone increments.
  - On vs_i, the last line's pixel count is also treated as a completed line before publish.
  - Published: frame_w_o = reference width; frame_h_o = line count; line_err_o = error flag (frame-local, recomputed each frame).
- Output counting:
  - scl_hs_i&scl_de_i: out counter reloads 1; its previous nonzero value is latched as the running output width.
  - scl_de_i alone increments the out counter.
  - On vs_i, out_w_o = latched width (or the counter value if it is the only line).
- All counters saturate at all-ones except frame_cnt_o, which wraps.
- Published outputs are registered and hold between frame starts.

Test Plan:
- Reset release, three frames of 16px x 4 lines (de_i contiguous), step never written -> scale_step_o=4096 throughout.
  - First irq only at the second vs_i: frame_w_o=16, frame_h_o=4, frame_cnt_o=1.
  - frame_cnt_o=2 after the third vs_i.
- Write 8192 mid-frame -> cfg_pend_o=1 next cycle, scale_step_o stays 4096 until one cycle after next vs_i, then 8192 and cfg_pend_o=0.
  - Bench drives 8 scaler-output pixels/line -> out_w_o=8 published at the following frame start.
- Write 20000, then 512 -> cfg_err_o=1, scale_step_o and cfg_pend_o unchanged.
  - A following write of 2048 clears cfg_err_o and sets cfg_pend_o.
- Write 12288 in the same cycle as vs_i with 8192 already pending -> 8192 committed; 12288 pending and committed at the next vs_i.
- Frame with line widths 16,16,15,16 -> line_err_o=1 at publish.
  - Next clean frame -> line_err_o=0.
- Assert rst_n=0 mid-frame with a pending step -> all outputs return to reset values immediately.
  - After release, the first vs_i produces no irq.
  - Stats appear from the second vs_i.

Source files
------------

// File: rtl/scaler_h_ctrl.sv
// Frame-synchronous control for the horizontal scaler: range-checked step writes applied only at
// frame start, per-frame input/output geometry measurement and a frame-boundary interrupt.
module scaler_h_ctrl #(
  parameter int PIXEL_STEP   = 4096,
  parameter int STEP_MIN     = 1024,
  parameter int STEP_MAX     = 16384,
  parameter int DEFAULT_STEP = 4096,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          cfg_step_i,
  input  logic                 cfg_wr_i,
  output logic                 cfg_pend_o,
  output logic                 cfg_err_o,
  input  logic                 de_i,
  input  logic                 hs_i,
  input  logic                 vs_i,
  input  logic                 scl_de_i,
  input  logic                 scl_hs_i,
  output logic [15:0]          scale_step_o,
  output logic [CNT_WIDTH-1:0] frame_w_o,
  output logic [CNT_WIDTH-1:0] frame_h_o,
  output logic [CNT_WIDTH-1:0] out_w_o,
  output logic [CNT_WIDTH-1:0] frame_cnt_o,
  output logic                 line_err_o,
  output logic                 irq_frame_o
);

  typedef enum logic [0:0] {
    S_WAIT_VS = 1'b0,
    S_ACTIVE  = 1'b1
  } state_t;

  localparam logic [15:0]          STEP_MIN_C     = 16'(STEP_MIN);
  localparam logic [15:0]          STEP_MAX_C     = 16'(STEP_MAX);
  localparam logic [15:0]          DEFAULT_STEP_C = 16'(DEFAULT_STEP);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO       = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE        = CNT_WIDTH'(1);
  // A parameter set whose unity step lies outside the legal range rejects every write.
  localparam logic                 PARAMS_OK      = (STEP_MIN <= PIXEL_STEP) && (PIXEL_STEP <= STEP_MAX);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_ONE;
    end
  endfunction

  state_t                 state_q, state_d;
  logic                   count_en_s, publish_s;
  logic                   step_ok_s;
  logic                   pend_q, pend_d;
  logic [15:0]            pval_q, pval_d;
  logic                   cerr_q, cerr_d;
  logic [15:0]            step_q, step_d;
  logic [CNT_WIDTH-1:0]   pix_q, pix_d;
  logic [CNT_WIDTH-1:0]   line_q, line_d;
  logic [CNT_WIDTH-1:0]   ref_q, ref_d;
  logic                   lerr_q, lerr_d;
  logic [CNT_WIDTH-1:0]   out_q, out_d;
  logic [CNT_WIDTH-1:0]   olat_q, olat_d;
  logic [CNT_WIDTH-1:0]   fw_q, fw_d;
  logic [CNT_WIDTH-1:0]   fh_q, fh_d;
  logic [CNT_WIDTH-1:0]   ow_q, ow_d;
  logic [CNT_WIDTH-1:0]   fcnt_q, fcnt_d;
  logic                   line_err_q, line_err_d;
  logic                   irq_q, irq_d;
  logic [CNT_WIDTH-1:0]   de_cnt_s;
  logic                   last_bad_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT_VS;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: the first frame start only arms measurement.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT_VS: begin
        if (vs_i) begin
          state_d = S_ACTIVE;
        end else begin
          state_d = S_WAIT_VS;
        end
      end
      S_ACTIVE: state_d = S_ACTIVE;
      default:  state_d = S_WAIT_VS;
    endcase
  end

  // FSM outputs: counting enable and the publish strobe.
  always_comb begin
    count_en_s = 1'b0;
    publish_s  = 1'b0;
    case (state_q)
      S_WAIT_VS: begin
        count_en_s = 1'b0;
        publish_s  = 1'b0;
      end
      S_ACTIVE: begin
        count_en_s = 1'b1;
        publish_s  = vs_i;
      end
      default: begin
        count_en_s = 1'b0;
        publish_s  = 1'b0;
      end
    endcase
  end

  // Step configuration: commit uses the value pending before this cycle's write.
  always_comb begin
    step_ok_s = PARAMS_OK && (cfg_step_i >= STEP_MIN_C) && (cfg_step_i <= STEP_MAX_C);
    pend_d    = pend_q;
    pval_d    = pval_q;
    cerr_d    = cerr_q;
    step_d    = step_q;
    if (vs_i && pend_q) begin
      step_d = pval_q;
      pend_d = 1'b0;
    end else begin
      step_d = step_q;
    end
    if (cfg_wr_i) begin
      if (step_ok_s) begin
        pend_d = 1'b1;
        pval_d = cfg_step_i;
        cerr_d = 1'b0;
      end else begin
        cerr_d = 1'b1;
      end
    end else begin
      cerr_d = cerr_q;
    end
  end

  // Line/pixel measurement and publish at frame start.
  always_comb begin
    de_cnt_s   = {{(CNT_WIDTH-1){1'b0}}, de_i};
    last_bad_s = (ref_q != CNT_ZERO) && (pix_q != CNT_ZERO) && (pix_q != ref_q);
    pix_d      = pix_q;
    line_d     = line_q;
    ref_d      = ref_q;
    lerr_d     = lerr_q;
    out_d      = out_q;
    olat_d     = olat_q;
    fw_d       = fw_q;
    fh_d       = fh_q;
    ow_d       = ow_q;
    fcnt_d     = fcnt_q;
    line_err_d = line_err_q;
    irq_d      = publish_s;
    if (publish_s) begin
      // The line still open at frame start counts as completed.
      fw_d       = (ref_q != CNT_ZERO) ? ref_q : pix_q;
      fh_d       = line_q;
      line_err_d = lerr_q | last_bad_s;
      ow_d       = (olat_q != CNT_ZERO) ? olat_q : out_q;
      fcnt_d     = fcnt_q + CNT_ONE;
    end else begin
      fw_d = fw_q;
    end
    if (vs_i) begin
      pix_d  = de_cnt_s;
      line_d = CNT_ONE;
      ref_d  = CNT_ZERO;
      lerr_d = 1'b0;
      out_d  = scl_de_i ? CNT_ONE : CNT_ZERO;
      olat_d = CNT_ZERO;
    end else if (count_en_s) begin
      if (hs_i) begin
        pix_d  = de_cnt_s;
        line_d = sat_inc(line_q);
        if (pix_q == CNT_ZERO) begin
          ref_d = ref_q;
        end else if (ref_q == CNT_ZERO) begin
          ref_d = pix_q;
        end else if (pix_q != ref_q) begin
          lerr_d = 1'b1;
        end else begin
          lerr_d = lerr_q;
        end
      end else if (de_i) begin
        pix_d = sat_inc(pix_q);
      end else begin
        pix_d = pix_q;
      end
      if (scl_hs_i && scl_de_i) begin
        out_d  = CNT_ONE;
        olat_d = (out_q != CNT_ZERO) ? out_q : olat_q;
      end else if (scl_de_i) begin
        out_d = sat_inc(out_q);
      end else begin
        out_d = out_q;
      end
    end else begin
      pix_d = pix_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= 1'b0;
      pval_q     <= 16'd0;
      cerr_q     <= 1'b0;
      step_q     <= DEFAULT_STEP_C;
      pix_q      <= CNT_ZERO;
      line_q     <= CNT_ZERO;
      ref_q      <= CNT_ZERO;
      lerr_q     <= 1'b0;
      out_q      <= CNT_ZERO;
      olat_q     <= CNT_ZERO;
      fw_q       <= CNT_ZERO;
      fh_q       <= CNT_ZERO;
      ow_q       <= CNT_ZERO;
      fcnt_q     <= CNT_ZERO;
      line_err_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      pval_q     <= pval_d;
      cerr_q     <= cerr_d;
      step_q     <= step_d;
      pix_q      <= pix_d;
      line_q     <= line_d;
      ref_q      <= ref_d;
      lerr_q     <= lerr_d;
      out_q      <= out_d;
      olat_q     <= olat_d;
      fw_q       <= fw_d;
      fh_q       <= fh_d;
      ow_q       <= ow_d;
      fcnt_q     <= fcnt_d;
      line_err_q <= line_err_d;
      irq_q      <= irq_d;
    end
  end

  assign cfg_pend_o   = pend_q;
  assign cfg_err_o    = cerr_q;
  assign scale_step_o = step_q;
  assign frame_w_o    = fw_q;
  assign frame_h_o    = fh_q;
  assign out_w_o      = ow_q;
  assign frame_cnt_o  = fcnt_q;
  assign line_err_o   = line_err_q;
  assign irq_frame_o  = irq_q;

endmodule

// File: tb/tb_scaler_h_ctrl.sv
// Bench for scaler_h_ctrl: frames described as per-line width lists, expectations derived from
// frame-level rules (first line width, line count, any width mismatch) and the step commit rules.
module tb_scaler_h_ctrl;

  logic        clk, rst_n;
  logic [15:0] cfg_step_i;
  logic        cfg_wr_i, cfg_pend_o, cfg_err_o;
  logic        de_i, hs_i, vs_i, scl_de_i, scl_hs_i;
  logic [15:0] scale_step_o, frame_w_o, frame_h_o, out_w_o, frame_cnt_o;
  logic        line_err_o, irq_frame_o;

  int total, bad;

  // model state
  logic [15:0] m_step, m_pval, m_fw, m_fh, m_ow, m_fcnt;
  logic        m_pend, m_err, m_lerr, m_started;
  logic [15:0] q_w, q_h, q_ow;
  logic        q_err;

  // frame description
  int f_n, f_ow, f_wrk;
  int f_w[8];
  logic [15:0] f_wrv;

  // snapshots of DUT and model
  logic        s_irq0, s_irq1, s_pend0, s_lerr, s_wpend, s_werr;
  logic [15:0] s_step0, s_fw, s_fh, s_ow, s_fcnt, s_wstep;
  logic        e_irq0, e_pend0, e_wpend, e_werr;
  logic [15:0] e_step0, e_wstep;

  scaler_h_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_step_i(cfg_step_i), .cfg_wr_i(cfg_wr_i),
    .cfg_pend_o(cfg_pend_o), .cfg_err_o(cfg_err_o),
    .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
    .scl_de_i(scl_de_i), .scl_hs_i(scl_hs_i),
    .scale_step_o(scale_step_o),
    .frame_w_o(frame_w_o), .frame_h_o(frame_h_o), .out_w_o(out_w_o),
    .frame_cnt_o(frame_cnt_o), .line_err_o(line_err_o), .irq_frame_o(irq_frame_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_step = 16'd4096; m_pval = 16'd0; m_pend = 1'b0; m_err = 1'b0;
    m_fw = 16'd0; m_fh = 16'd0; m_ow = 16'd0; m_fcnt = 16'd0; m_lerr = 1'b0;
    m_started = 1'b0;
  endtask

  // One clock of stimulus; the step configuration model follows the commit/write rules.
  task automatic cyc(input logic vs, input logic hs, input logic de, input logic shs,
                     input logic sde, input logic wr, input logic [15:0] val);
    vs_i = vs; hs_i = hs; de_i = de; scl_hs_i = shs; scl_de_i = sde;
    cfg_wr_i = wr; cfg_step_i = val;
    if (vs && m_pend) begin
      m_step = m_pval;
      m_pend = 1'b0;
    end
    if (wr) begin
      if (val >= 16'd1024 && val <= 16'd16384) begin
        m_pend = 1'b1; m_pval = val; m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic set_frame(input int n, input int w, input int ow, input int wrk, input logic [15:0] wrv);
    f_n = n; f_ow = ow; f_wrk = wrk; f_wrv = wrv;
    for (int i = 0; i < 8; i++) f_w[i] = w;
  endtask

  // Drives one full frame starting with its vs cycle; snapshots outputs at key cycles.
  task automatic drive_frame();
    int k;
    k = 0;
    for (int l = 0; l < f_n; l++) begin
      int len;
      len = ((f_w[l] > f_ow + 1) ? f_w[l] : f_ow + 1) + 2;
      for (int c = 0; c < len; c++) begin
        if (k == 0) begin
          e_irq0 = m_started;
          if (m_started) begin
            m_fw = q_w; m_fh = q_h; m_lerr = q_err; m_ow = q_ow;
            m_fcnt = m_fcnt + 16'd1;
          end
          m_started = 1'b1;
        end
        cyc((l == 0) && (c == 0), c == 0, c < f_w[l], (c == 1) && (f_ow > 0),
            (c >= 1) && (c <= f_ow), k == f_wrk, f_wrv);
        if (k == 0) begin
          s_irq0 = irq_frame_o; s_step0 = scale_step_o; s_pend0 = cfg_pend_o;
          s_fw = frame_w_o; s_fh = frame_h_o; s_ow = out_w_o; s_fcnt = frame_cnt_o;
          s_lerr = line_err_o;
          e_step0 = m_step; e_pend0 = m_pend;
        end
        if (k == 1) s_irq1 = irq_frame_o;
        if (k == f_wrk) begin
          s_wpend = cfg_pend_o; s_werr = cfg_err_o; s_wstep = scale_step_o;
          e_wpend = m_pend; e_werr = m_err; e_wstep = m_step;
        end
        k++;
      end
    end
    q_w = 16'(f_w[0]); q_h = 16'(f_n); q_ow = 16'(f_ow); q_err = 1'b0;
    for (int l = 1; l < f_n; l++) if (f_w[l] != f_w[0]) q_err = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    total++; if (scale_step_o !== 16'd4096) begin bad++; $display("FAIL reset_step got=%0d exp=4096", scale_step_o); end
    total++; if (cfg_pend_o !== 1'b0) begin bad++; $display("FAIL reset_pend got=%b exp=0", cfg_pend_o); end
    total++; if (cfg_err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", cfg_err_o); end
    total++; if (frame_w_o !== 16'd0) begin bad++; $display("FAIL reset_fw got=%0d exp=0", frame_w_o); end
    total++; if (frame_h_o !== 16'd0) begin bad++; $display("FAIL reset_fh got=%0d exp=0", frame_h_o); end
    total++; if (out_w_o !== 16'd0) begin bad++; $display("FAIL reset_ow got=%0d exp=0", out_w_o); end
    total++; if (frame_cnt_o !== 16'd0) begin bad++; $display("FAIL reset_fcnt got=%0d exp=0", frame_cnt_o); end
    total++; if (line_err_o !== 1'b0) begin bad++; $display("FAIL reset_lerr got=%b exp=0", line_err_o); end
    total++; if (irq_frame_o !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq_frame_o); end
    rst_n = 1'b1;
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic test_basic_frames();
    set_frame(4, 16, 0, -1, 16'd0);
    drive_frame();
    total++; if (s_irq0 !== 1'b0) begin bad++; $display("FAIL basic_first_irq got=%b exp=0", s_irq0); end
    total++; if (s_step0 !== 16'd4096) begin bad++; $display("FAIL basic_step1 got=%0d exp=4096", s_step0); end
    drive_frame();
    total++; if (s_irq0 !== 1'b1) begin bad++; $display("FAIL basic_irq2 got=%b exp=1", s_irq0); end
    total++; if (s_irq1 !== 1'b0) begin bad++; $display("FAIL basic_irq_pulse got=%b exp=0", s_irq1); end
    total++; if (s_fw !== 16'd16) begin bad++; $display("FAIL basic_fw got=%0d exp=16", s_fw); end
    total++; if (s_fh !== 16'd4) begin bad++; $display("FAIL basic_fh got=%0d exp=4", s_fh); end
    total++; if (s_fcnt !== 16'd1) begin bad++; $display("FAIL basic_fcnt1 got=%0d exp=1", s_fcnt); end
    total++; if (s_lerr !== 1'b0) begin bad++; $display("FAIL basic_lerr got=%b exp=0", s_lerr); end
    drive_frame();
    total++; if (s_fcnt !== 16'd2) begin bad++; $display("FAIL basic_fcnt2 got=%0d exp=2", s_fcnt); end
    total++; if (s_step0 !== 16'd4096) begin bad++; $display("FAIL basic_step3 got=%0d exp=4096", s_step0); end
  endtask

  task automatic test_cfg_commit();
    set_frame(4, 16, 8, 10, 16'd8192);
    drive_frame();
    total++; if (s_wpend !== 1'b1) begin bad++; $display("FAIL commit_pend got=%b exp=1", s_wpend); end
    total++; if (s_wstep !== 16'd4096) begin bad++; $display("FAIL commit_hold got=%0d exp=4096", s_wstep); end
    total++; if (scale_step_o !== 16'd4096) begin bad++; $display("FAIL commit_hold_end got=%0d exp=4096", scale_step_o); end
    set_frame(4, 16, 8, -1, 16'd0);
    drive_frame();
    total++; if (s_step0 !== 16'd8192) begin bad++; $display("FAIL commit_step got=%0d exp=8192", s_step0); end
    total++; if (s_pend0 !== 1'b0) begin bad++; $display("FAIL commit_pend_clr got=%b exp=0", s_pend0); end
    total++; if (s_ow !== 16'd8) begin bad++; $display("FAIL commit_out_w got=%0d exp=8", s_ow); end
  endtask

  task automatic test_cfg_err();
    set_frame(4, 16, 8, 5, 16'd20000);
    drive_frame();
    total++; if (s_werr !== 1'b1) begin bad++; $display("FAIL err_hi got=%b exp=1", s_werr); end
    total++; if (s_wpend !== 1'b0) begin bad++; $display("FAIL err_hi_pend got=%b exp=0", s_wpend); end
    total++; if (s_wstep !== 16'd8192) begin bad++; $display("FAIL err_hi_step got=%0d exp=8192", s_wstep); end
    set_frame(4, 16, 8, 5, 16'd512);
    drive_frame();
    total++; if (s_werr !== 1'b1) begin bad++; $display("FAIL err_lo got=%b exp=1", s_werr); end
    total++; if (s_wpend !== 1'b0) begin bad++; $display("FAIL err_lo_pend got=%b exp=0", s_wpend); end
    set_frame(4, 16, 8, 5, 16'd2048);
    drive_frame();
    total++; if (s_werr !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", s_werr); end
    total++; if (s_wpend !== 1'b1) begin bad++; $display("FAIL err_clear_pend got=%b exp=1", s_wpend); end
  endtask

  task automatic test_same_cycle();
    set_frame(3, 16, 8, 5, 16'd8192);
    drive_frame();
    total++; if (s_step0 !== 16'd2048) begin bad++; $display("FAIL same_prev_commit got=%0d exp=2048", s_step0); end
    set_frame(3, 16, 8, 0, 16'd12288);
    drive_frame();
    total++; if (s_step0 !== 16'd8192) begin bad++; $display("FAIL same_commit_old got=%0d exp=8192", s_step0); end
    total++; if (s_wpend !== 1'b1) begin bad++; $display("FAIL same_new_pend got=%b exp=1", s_wpend); end
    set_frame(3, 16, 8, -1, 16'd0);
    drive_frame();
    total++; if (s_step0 !== 16'd12288) begin bad++; $display("FAIL same_commit_new got=%0d exp=12288", s_step0); end
    total++; if (s_pend0 !== 1'b0) begin bad++; $display("FAIL same_pend_clr got=%b exp=0", s_pend0); end
  endtask

  task automatic test_line_err();
    set_frame(4, 16, 8, -1, 16'd0);
    f_w[2] = 15;
    drive_frame();
    set_frame(4, 16, 8, -1, 16'd0);
    drive_frame();
    total++; if (s_lerr !== 1'b1) begin bad++; $display("FAIL lerr_set got=%b exp=1", s_lerr); end
    total++; if (s_fw !== 16'd16) begin bad++; $display("FAIL lerr_fw got=%0d exp=16", s_fw); end
    drive_frame();
    total++; if (s_lerr !== 1'b0) begin bad++; $display("FAIL lerr_clean got=%b exp=0", s_lerr); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      int tot, wr;
      set_frame(int'($urandom_range(1, 6)), int'($urandom_range(1, 24)), int'($urandom_range(0, 10)), -1, 16'd0);
      for (int l = 0; l < f_n; l++) if ($urandom_range(0, 3) == 0) f_w[l] = int'($urandom_range(1, 24));
      tot = 0;
      for (int l = 0; l < f_n; l++) tot += ((f_w[l] > f_ow + 1) ? f_w[l] : f_ow + 1) + 2;
      wr = int'($urandom_range(0, 1));
      if (wr == 1) begin
        f_wrk = int'($urandom_range(0, tot - 1));
        f_wrv = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(1024, 16384)) : 16'($urandom_range(0, 65535));
      end
      drive_frame();
      total++; if (s_irq0 !== e_irq0) begin bad++; $display("FAIL rnd_irq it=%0d got=%b exp=%b", it, s_irq0, e_irq0); end
      total++; if (s_step0 !== e_step0) begin bad++; $display("FAIL rnd_step it=%0d got=%0d exp=%0d", it, s_step0, e_step0); end
      total++; if (s_pend0 !== e_pend0) begin bad++; $display("FAIL rnd_pend it=%0d got=%b exp=%b", it, s_pend0, e_pend0); end
      total++; if (s_fw !== m_fw) begin bad++; $display("FAIL rnd_fw it=%0d got=%0d exp=%0d", it, s_fw, m_fw); end
      total++; if (s_fh !== m_fh) begin bad++; $display("FAIL rnd_fh it=%0d got=%0d exp=%0d", it, s_fh, m_fh); end
      total++; if (s_ow !== m_ow) begin bad++; $display("FAIL rnd_ow it=%0d got=%0d exp=%0d", it, s_ow, m_ow); end
      total++; if (s_lerr !== m_lerr) begin bad++; $display("FAIL rnd_lerr it=%0d got=%b exp=%b", it, s_lerr, m_lerr); end
      total++; if (s_fcnt !== m_fcnt) begin bad++; $display("FAIL rnd_fcnt it=%0d got=%0d exp=%0d", it, s_fcnt, m_fcnt); end
      if (wr == 1) begin
        total++; if (s_wpend !== e_wpend) begin bad++; $display("FAIL rnd_wpend it=%0d got=%b exp=%b", it, s_wpend, e_wpend); end
        total++; if (s_werr !== e_werr) begin bad++; $display("FAIL rnd_werr it=%0d got=%b exp=%b", it, s_werr, e_werr); end
      end
    end
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd5120);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    total++; if (cfg_pend_o !== 1'b1) begin bad++; $display("FAIL mid_pend_before got=%b exp=1", cfg_pend_o); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (scale_step_o !== 16'd4096) begin bad++; $display("FAIL mid_rst_step got=%0d exp=4096", scale_step_o); end
    total++; if (cfg_pend_o !== 1'b0) begin bad++; $display("FAIL mid_rst_pend got=%b exp=0", cfg_pend_o); end
    total++; if (frame_w_o !== 16'd0) begin bad++; $display("FAIL mid_rst_fw got=%0d exp=0", frame_w_o); end
    total++; if (frame_h_o !== 16'd0) begin bad++; $display("FAIL mid_rst_fh got=%0d exp=0", frame_h_o); end
    total++; if (out_w_o !== 16'd0) begin bad++; $display("FAIL mid_rst_ow got=%0d exp=0", out_w_o); end
    total++; if (frame_cnt_o !== 16'd0) begin bad++; $display("FAIL mid_rst_fcnt got=%0d exp=0", frame_cnt_o); end
    model_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    set_frame(4, 16, 8, -1, 16'd0);
    drive_frame();
    total++; if (s_irq0 !== 1'b0) begin bad++; $display("FAIL mid_first_irq got=%b exp=0", s_irq0); end
    total++; if (s_step0 !== 16'd4096) begin bad++; $display("FAIL mid_step got=%0d exp=4096", s_step0); end
    total++; if (s_fcnt !== 16'd0) begin bad++; $display("FAIL mid_fcnt0 got=%0d exp=0", s_fcnt); end
    drive_frame();
    total++; if (s_irq0 !== 1'b1) begin bad++; $display("FAIL mid_irq2 got=%b exp=1", s_irq0); end
    total++; if (s_fw !== 16'd16) begin bad++; $display("FAIL mid_fw got=%0d exp=16", s_fw); end
    total++; if (s_fh !== 16'd4) begin bad++; $display("FAIL mid_fh got=%0d exp=4", s_fh); end
    total++; if (s_fcnt !== 16'd1) begin bad++; $display("FAIL mid_fcnt1 got=%0d exp=1", s_fcnt); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; cfg_step_i = 16'd0; cfg_wr_i = 1'b0;
    de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0; scl_de_i = 1'b0; scl_hs_i = 1'b0;
    q_w = 16'd0; q_h = 16'd0; q_ow = 16'd0; q_err = 1'b0;
    model_reset();
    test_reset();
    test_basic_frames();
    test_cfg_commit();
    test_cfg_err();
    test_same_cycle();
    test_line_err();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
